// File: rtl/freq_step_ctrl.sv
// Key-driven frequency step controller: debounces active-low up/down keys, emits press and
// hold-to-repeat ticks, and steps a bounded index that drives a registered frequency word.
module freq_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter bit REPEAT_EN       = 1'b1,
  parameter int NUM_STEPS       = 100,
  parameter int RESET_IDX       = 0,
  parameter bit WRAP            = 1'b0,
  parameter int FREQ_W          = 32,
  parameter int BASE_FREQ       = 1000,
  parameter int STEP_FREQ       = 1000,
  localparam int IDX_W          = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              freq_up_key_i,
  input  logic              freq_down_key_i,
  output logic [FREQ_W-1:0] frequency_o,
  output logic [IDX_W-1:0]  freq_num_o,
  output logic              freq_up_tick_o,
  output logic              freq_down_tick_o,
  output logic              at_min_o,
  output logic              at_max_o
);

  localparam int DEB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] DELAY_LOAD = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] PERIOD_LOAD = TMR_W'(REPEAT_PERIOD - 1);
  localparam logic [IDX_W-1:0] IDX_MAX    = IDX_W'(NUM_STEPS - 1);
  localparam logic [IDX_W-1:0] IDX_RESET  = IDX_W'(RESET_IDX);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RPT  = 2'd2
  } state_e;

  // Reducing modulo 2^FREQ_W at every step gives the same low FREQ_W bits as wider arithmetic.
  function automatic logic [FREQ_W-1:0] freq_of(input logic [IDX_W-1:0] idx);
    return FREQ_W'(BASE_FREQ) + FREQ_W'(idx) * FREQ_W'(STEP_FREQ);
  endfunction

  logic [1:0] key_raw;
  logic [1:0] strobe;
  logic [1:0] tick_q;

  assign key_raw = {freq_down_key_i, freq_up_key_i};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_key
      logic             sync1_q;
      logic             sync2_q;
      logic             db_q;
      logic [DEB_W-1:0] deb_cnt_q;
      state_e           state_q, state_d;
      logic [TMR_W-1:0] tmr_q, tmr_d;
      logic             strobe_q, strobe_d;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          sync1_q   <= 1'b1;
          sync2_q   <= 1'b1;
          db_q      <= 1'b1;
          deb_cnt_q <= '0;
        end else begin
          sync1_q <= key_raw[gi];
          sync2_q <= sync1_q;
          if (sync2_q == db_q) begin
            deb_cnt_q <= '0;
          end else if (deb_cnt_q == DEB_LAST) begin
            db_q      <= sync2_q;
            deb_cnt_q <= '0;
          end else begin
            deb_cnt_q <= deb_cnt_q + 1'b1;
          end
        end
      end

      // IDLE is only entered with the key released, so a low level there is the falling edge.
      always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        strobe_d = 1'b0;
        case (state_q)
          ST_IDLE: begin
            if (!db_q) begin
              strobe_d = 1'b1;
              state_d  = ST_HOLD;
              if (REPEAT_EN) tmr_d = DELAY_LOAD;
            end
          end
          ST_HOLD: begin
            if (db_q) begin
              state_d = ST_IDLE;
            end else if (REPEAT_EN && (tmr_q == '0)) begin
              strobe_d = 1'b1;
              tmr_d    = PERIOD_LOAD;
              state_d  = ST_RPT;
            end else if (tmr_q != '0) begin
              tmr_d = tmr_q - 1'b1;
            end
          end
          ST_RPT: begin
            if (db_q) begin
              state_d = ST_IDLE;
            end else if (tmr_q == '0) begin
              strobe_d = 1'b1;
              tmr_d    = PERIOD_LOAD;
            end else begin
              tmr_d = tmr_q - 1'b1;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          state_q  <= ST_IDLE;
          tmr_q    <= '0;
          strobe_q <= 1'b0;
        end else begin
          state_q  <= state_d;
          tmr_q    <= tmr_d;
          strobe_q <= strobe_d;
        end
      end

      assign strobe[gi] = strobe_q;
    end
  endgenerate

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [FREQ_W-1:0] freq_q;

  // Bit 0 is the up key, bit 1 the down key; simultaneous ticks cancel.
  always_comb begin
    idx_d = idx_q;
    case (tick_q)
      2'b01: begin
        if (idx_q == IDX_MAX) idx_d = WRAP ? '0 : idx_q;
        else                  idx_d = idx_q + 1'b1;
      end
      2'b10: begin
        if (idx_q == '0) idx_d = WRAP ? IDX_MAX : idx_q;
        else             idx_d = idx_q - 1'b1;
      end
      default: idx_d = idx_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tick_q <= 2'b00;
      idx_q  <= IDX_RESET;
      freq_q <= freq_of(IDX_RESET);
    end else begin
      tick_q <= strobe;
      idx_q  <= idx_d;
      freq_q <= freq_of(idx_q);
    end
  end

  assign frequency_o      = freq_q;
  assign freq_num_o       = idx_q;
  assign freq_up_tick_o   = tick_q[0];
  assign freq_down_tick_o = tick_q[1];
  assign at_min_o         = (idx_q == '0);
  assign at_max_o         = (idx_q == IDX_MAX);

endmodule

// File: tb/tb_freq_step_ctrl.sv
// Directed bench for freq_step_ctrl: a saturating and a wrapping instance share the key stimulus.
module tb_freq_step_ctrl;
  localparam int IDX_W = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic up_n = 1'b1;
  logic dn_n = 1'b1;

  logic [31:0]      freq_s, freq_w;
  logic [IDX_W-1:0] num_s, num_w;
  logic up_s, dn_s, min_s, max_s;
  logic up_w, dn_w, min_w, max_w;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int up_t[$];
  int dn_t[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Tick times are logged relative to the cycle the current key press started.
  always @(negedge clk) begin
    if (up_s) up_t.push_back(cyc - t0);
    if (dn_s) dn_t.push_back(cyc - t0);
  end

  freq_step_ctrl #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8), .REPEAT_EN(1'b1),
    .NUM_STEPS(8), .RESET_IDX(0), .WRAP(1'b0), .FREQ_W(32),
    .BASE_FREQ(1000), .STEP_FREQ(1000)
  ) u_sat (
    .clk_i(clk), .rst_i(rst), .freq_up_key_i(up_n), .freq_down_key_i(dn_n),
    .frequency_o(freq_s), .freq_num_o(num_s), .freq_up_tick_o(up_s),
    .freq_down_tick_o(dn_s), .at_min_o(min_s), .at_max_o(max_s)
  );

  freq_step_ctrl #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8), .REPEAT_EN(1'b1),
    .NUM_STEPS(8), .RESET_IDX(0), .WRAP(1'b1), .FREQ_W(32),
    .BASE_FREQ(1000), .STEP_FREQ(1000)
  ) u_wrap (
    .clk_i(clk), .rst_i(rst), .freq_up_key_i(up_n), .freq_down_key_i(dn_n),
    .frequency_o(freq_w), .freq_num_o(num_w), .freq_up_tick_o(up_w),
    .freq_down_tick_o(dn_w), .at_min_o(min_w), .at_max_o(max_w)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end else begin
      $display("chk  %s got %0d", tag, got);
    end
  endtask

  function automatic int q_at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    up_n = 1'b1;
    dn_n = 1'b1;
    step(2);
    rst = 1'b0;
    step(2);
  endtask

  task automatic tap_up();
    up_n = 1'b0;
    step(10);
    up_n = 1'b1;
    step(12);
  endtask

  task automatic tap_dn();
    dn_n = 1'b0;
    step(10);
    dn_n = 1'b1;
    step(12);
  endtask

  int rpt_exp[6] = '{8, 28, 36, 44, 52, 60};
  int n0, n1;

  initial begin
    step(1);
    do_reset();
    chk("rst_num", num_s, 0);
    chk("rst_freq", freq_s, 1000);
    chk("rst_up_tick", up_s, 0);
    chk("rst_dn_tick", dn_s, 0);
    chk("rst_min", min_s, 1);
    chk("rst_max", max_s, 0);

    // single press, held 10 cycles
    n0 = up_t.size(); t0 = cyc; up_n = 1'b0;
    step(7); chk("single_tick_c7", up_s, 0);
    step(1); chk("single_tick_c8", up_s, 1);
    step(1); chk("single_num_c9", num_s, 1); chk("single_freq_c9", freq_s, 1000);
    step(1); chk("single_freq_c10", freq_s, 2000);
    up_n = 1'b1;
    step(30);
    chk("single_count", up_t.size() - n0, 1);
    chk("single_time", q_at(up_t, n0), 8);

    // hold-to-repeat for 60 cycles
    do_reset();
    n0 = up_t.size(); t0 = cyc; up_n = 1'b0;
    step(60); up_n = 1'b1;
    step(30);
    chk("rpt_count", up_t.size() - n0, 6);
    for (int i = 0; i < 6; i++) chk($sformatf("rpt_time%0d", i), q_at(up_t, n0 + i), rpt_exp[i]);
    chk("rpt_num", num_s, 6);
    chk("rpt_freq", freq_s, 7000);

    // bounds: saturate vs wrap
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      tap_up();
      if (i == 7) begin
        chk("p7_num_sat", num_s, 7); chk("p7_max_sat", max_s, 1); chk("p7_freq_sat", freq_s, 8000);
        chk("p7_num_wrap", num_w, 7);
      end
      if (i == 8) begin
        chk("p8_num_wrap", num_w, 0); chk("p8_freq_wrap", freq_w, 1000); chk("p8_min_wrap", min_w, 1);
      end
    end
    chk("p9_num_sat", num_s, 7); chk("p9_freq_sat", freq_s, 8000); chk("p9_max_sat", max_s, 1);
    chk("p9_num_wrap", num_w, 1);
    do_reset();
    tap_dn();
    chk("dn0_num_sat", num_s, 0); chk("dn0_min_sat", min_s, 1); chk("dn0_freq_sat", freq_s, 1000);
    chk("dn0_num_wrap", num_w, 7); chk("dn0_freq_wrap", freq_w, 8000); chk("dn0_max_wrap", max_w, 1);

    // bounce: three 3-cycle lows with 1-cycle highs, then stable low from cycle 12
    do_reset();
    n0 = up_t.size(); t0 = cyc;
    for (int i = 0; i < 3; i++) begin
      up_n = 1'b0; step(3);
      up_n = 1'b1; step(1);
    end
    up_n = 1'b0; step(16);
    up_n = 1'b1; step(20);
    chk("bounce_count", up_t.size() - n0, 1);
    chk("bounce_time", q_at(up_t, n0), 20);
    chk("bounce_num", num_s, 1);

    // both keys in the same cycle
    do_reset();
    n0 = up_t.size(); n1 = dn_t.size(); t0 = cyc;
    up_n = 1'b0; dn_n = 1'b0;
    step(8); chk("both_up_tick", up_s, 1); chk("both_dn_tick", dn_s, 1);
    step(1); chk("both_num_sat", num_s, 0); chk("both_num_wrap", num_w, 0);
    step(1); chk("both_freq_wrap", freq_w, 1000);
    up_n = 1'b1; dn_n = 1'b1;
    step(30);
    chk("both_up_count", up_t.size() - n0, 1);
    chk("both_dn_count", dn_t.size() - n1, 1);

    // reset during a hold
    do_reset();
    n0 = up_t.size(); t0 = cyc; up_n = 1'b0;
    step(12); chk("hold_num_pre", num_s, 1);
    rst = 1'b1;
    step(1);
    chk("hold_rst_num", num_s, 0); chk("hold_rst_freq", freq_s, 1000);
    chk("hold_rst_tick", up_s, 0); chk("hold_rst_min", min_s, 1);
    rst = 1'b0;
    step(7); chk("hold_tick_c20", up_s, 0);
    step(1); chk("hold_tick_c21", up_s, 1);
    step(1); chk("hold_num_c22", num_s, 1);
    up_n = 1'b1;
    step(30);
    chk("hold_count", up_t.size() - n0, 2);
    chk("hold_time0", q_at(up_t, n0), 8);
    chk("hold_time1", q_at(up_t, n0 + 1), 21);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
